// File: rtl/decode_stage_pkg.sv
// decode_stage_pkg: opcodes, ALU op encodings and control word shared by the ID stage
package decode_stage_pkg;
    localparam int NREG   = 32;
    localparam int XLEN   = 32;
    localparam int CTRL_W = 9;
    localparam logic [5:0] OP_R    = 6'b000000;
    localparam logic [5:0] OP_LW   = 6'b100011;
    localparam logic [5:0] OP_SW   = 6'b101011;
    localparam logic [5:0] OP_BEQ  = 6'b000100;
    localparam logic [5:0] OP_ADDI = 6'b001000;
    localparam logic [5:0] OP_J    = 6'b000010;
    localparam logic [1:0] ALU_ADD   = 2'b00;
    localparam logic [1:0] ALU_SUB   = 2'b01;
    localparam logic [1:0] ALU_FUNCT = 2'b10;
    typedef struct packed {
        logic       reg_write;
        logic       mem_to_reg;
        logic       mem_read;
        logic       mem_write;
        logic       branch;
        logic       alu_src;
        logic       reg_dst;
        logic [1:0] alu_op;
    } ctrl_t;
    localparam ctrl_t CTRL_R    = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, ALU_FUNCT};
    localparam ctrl_t CTRL_LW   = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, ALU_ADD};
    localparam ctrl_t CTRL_SW   = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, ALU_ADD};
    localparam ctrl_t CTRL_BEQ  = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, ALU_SUB};
    localparam ctrl_t CTRL_ADDI = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, ALU_ADD};
    // j and unknown opcodes both produce an all-zero (bubble) control word
    function automatic ctrl_t decode(input logic [5:0] op);
        return op == OP_R    ? CTRL_R    :
               op == OP_LW   ? CTRL_LW   :
               op == OP_SW   ? CTRL_SW   :
               op == OP_BEQ  ? CTRL_BEQ  :
               op == OP_ADDI ? CTRL_ADDI : '0;
    endfunction
endpackage

// File: rtl/decode_stage_if.sv
// decode_stage_if: IF/ID link between fetch (master) and decode (slave)
import decode_stage_pkg::*;

interface decode_stage_if;
    logic [XLEN-1:0] Instruccion;
    logic [XLEN-1:0] Adder;
    logic            flush;
    logic            jump;
    logic [XLEN-1:0] jump_address;
    logic            stall;
    modport master (output Instruccion, Adder, flush, input jump, jump_address, stall);
    modport slave  (input Instruccion, Adder, flush, output jump, jump_address, stall);
endinterface

// File: rtl/decode_stage_register_file.sv
// register_file: 2R/1W register file with sync clear, hardwired $0 and write-to-read bypass
import decode_stage_pkg::*;

module register_file #(
    parameter int NREG = decode_stage_pkg::NREG,
    parameter int XLEN = decode_stage_pkg::XLEN
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [4:0]      ra,
    input  logic [4:0]      rb,
    output logic [XLEN-1:0] rd_a,
    output logic [XLEN-1:0] rd_b,
    input  logic            we,
    input  logic [4:0]      wa,
    input  logic [XLEN-1:0] wd
);
    logic [XLEN-1:0] regs [NREG];
    always_ff @(posedge clk) begin
        if (rst) regs <= '{default: '0};
        else if (we && wa != 5'd0) regs[wa] <= wd;
    end
    always_comb begin
        rd_a = ra == 5'd0 ? '0 : (we && wa == ra) ? wd : regs[ra];
        rd_b = rb == 5'd0 ? '0 : (we && wa == rb) ? wd : regs[rb];
    end
endmodule

// File: rtl/decode_stage.sv
// decode_stage: MIPS ID stage - control decode, load-use detection, jump target and ID/EX register
import decode_stage_pkg::*;

module decode_stage #(
    parameter int NREG = decode_stage_pkg::NREG,
    parameter int XLEN = decode_stage_pkg::XLEN
) (
    input  logic             clk,
    input  logic             rst,
    decode_stage_if.slave    ifid,
    input  logic             wb_en,
    input  logic [4:0]       wb_addr,
    input  logic [XLEN-1:0]  wb_data,
    output logic [XLEN-1:0]  pc4_ex,
    output logic [XLEN-1:0]  rs_data_ex,
    output logic [XLEN-1:0]  rt_data_ex,
    output logic [XLEN-1:0]  imm_ex,
    output logic [4:0]       rs_ex,
    output logic [4:0]       rt_ex,
    output logic [4:0]       rd_ex,
    output ctrl_t            ctrl_ex
);
    logic [5:0]      op;
    logic [4:0]      rs, rt, rd;
    logic [XLEN-1:0] rs_data, rt_data;
    logic            stall;
    assign op = ifid.Instruccion[31:26];
    assign rs = ifid.Instruccion[25:21];
    assign rt = ifid.Instruccion[20:16];
    assign rd = ifid.Instruccion[15:11];
    register_file #(.NREG(NREG), .XLEN(XLEN)) u_rf (
        .clk(clk), .rst(rst), .ra(rs), .rb(rt), .rd_a(rs_data), .rd_b(rt_data),
        .we(wb_en), .wa(wb_addr), .wd(wb_data)
    );
    // flush wins: a killed instruction can neither stall the front end nor redirect it
    assign stall = ctrl_ex.mem_read && rt_ex != 5'd0 && (rt_ex == rs || rt_ex == rt) && !ifid.flush;
    assign ifid.stall = stall;
    assign ifid.jump = op == OP_J && !stall && !ifid.flush;
    assign ifid.jump_address = {ifid.Adder[31:28], ifid.Instruccion[25:0], 2'b00};
    always_ff @(posedge clk) begin
        if (rst || stall || ifid.flush) begin
            pc4_ex     <= '0;
            rs_data_ex <= '0;
            rt_data_ex <= '0;
            imm_ex     <= '0;
            rs_ex      <= '0;
            rt_ex      <= '0;
            rd_ex      <= '0;
            ctrl_ex    <= '0;
        end else begin
            pc4_ex     <= ifid.Adder;
            rs_data_ex <= rs_data;
            rt_data_ex <= rt_data;
            imm_ex     <= {{(XLEN-16){ifid.Instruccion[15]}}, ifid.Instruccion[15:0]};
            rs_ex      <= rs;
            rt_ex      <= rt;
            rd_ex      <= rd;
            ctrl_ex    <= decode(op);
        end
    end
endmodule

// File: tb/tb_decode_stage.sv
// tb_decode_stage: directed self-checking bench for the ID stage
import decode_stage_pkg::*;

module tb_decode_stage;
    logic        clk = 1'b0;
    logic        rst;
    logic        wb_en;
    logic [4:0]  wb_addr;
    logic [31:0] wb_data;
    logic [31:0] pc4_ex, rs_data_ex, rt_data_ex, imm_ex;
    logic [4:0]  rs_ex, rt_ex, rd_ex;
    ctrl_t       ctrl_ex;
    int          checks = 0;
    int          errors = 0;

    decode_stage_if ifid ();

    decode_stage dut (
        .clk(clk), .rst(rst), .ifid(ifid),
        .wb_en(wb_en), .wb_addr(wb_addr), .wb_data(wb_data),
        .pc4_ex(pc4_ex), .rs_data_ex(rs_data_ex), .rt_data_ex(rt_data_ex), .imm_ex(imm_ex),
        .rs_ex(rs_ex), .rt_ex(rt_ex), .rd_ex(rd_ex), .ctrl_ex(ctrl_ex)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst = 1'b1;
        ifid.Instruccion = $urandom;
        ifid.Adder = $urandom;
        ifid.flush = 1'b0;
        wb_en = 1'b1;
        wb_addr = 5'd7;
        wb_data = 32'h0000_1234;
        step();
        ifid.Instruccion = $urandom;
        ifid.Adder = $urandom;
        ifid.flush = 1'($urandom);
        step();
        check("rst_ctrl", 32'(ctrl_ex), 32'd0);
        check("rst_pc4", pc4_ex, 32'd0);
        check("rst_rs_data", rs_data_ex, 32'd0);
        check("rst_rt_data", rt_data_ex, 32'd0);
        check("rst_imm", imm_ex, 32'd0);
        check("rst_fields", {17'd0, rs_ex, rt_ex, rd_ex}, 32'd0);
        check("rst_stall", 32'(ifid.stall), 32'd0);
        rst = 1'b0;
        wb_en = 1'b0;
        ifid.flush = 1'b0;
        ifid.Adder = 32'h0000_0104;
        for (int i = 1; i < 32; i++) begin
            ifid.Instruccion = {6'b0, 5'(i), 5'(i), 16'h0020};
            step();
            check($sformatf("rst_reg%0d_rs", i), rs_data_ex, 32'd0);
            check($sformatf("rst_reg%0d_rt", i), rt_data_ex, 32'd0);
        end

        // write with same-cycle bypass
        wb_en = 1'b1;
        wb_addr = 5'd5;
        wb_data = 32'hDEAD_BEEF;
        ifid.Instruccion = 32'h00A0_1820;
        step();
        check("byp_rs_data", rs_data_ex, 32'hDEAD_BEEF);
        check("byp_ctrl", 32'(ctrl_ex), 32'(9'b100000110));
        check("byp_rd", 32'(rd_ex), 32'd3);
        check("byp_pc4", pc4_ex, 32'h0000_0104);
        wb_en = 1'b0;
        step();
        check("stored_rs_data", rs_data_ex, 32'hDEAD_BEEF);
        wb_en = 1'b1;
        wb_addr = 5'd0;
        wb_data = 32'hFFFF_FFFF;
        ifid.Instruccion = 32'h0000_0820;
        step();
        check("r0_bypass", rs_data_ex, 32'd0);
        wb_en = 1'b0;
        step();
        check("r0_stored", rs_data_ex, 32'd0);

        // load-use hazard
        ifid.Instruccion = 32'h8C22_0004;
        step();
        check("lw_ctrl", 32'(ctrl_ex), 32'(9'b111001000));
        check("lw_imm", imm_ex, 32'd4);
        ifid.Instruccion = 32'h0043_2020;
        #1;
        check("lu_stall", 32'(ifid.stall), 32'd1);
        step();
        check("lu_bubble_ctrl", 32'(ctrl_ex), 32'd0);
        check("lu_bubble_rs", 32'(rs_ex), 32'd0);
        check("lu_stall_clear", 32'(ifid.stall), 32'd0);
        step();
        check("lu_add_ctrl", 32'(ctrl_ex), 32'(9'b100000110));
        check("lu_add_rs", 32'(rs_ex), 32'd2);
        check("lu_add_rt", 32'(rt_ex), 32'd3);
        check("lu_add_rd", 32'(rd_ex), 32'd4);

        // jump
        ifid.Instruccion = 32'h0800_0010;
        ifid.Adder = 32'h4000_0008;
        #1;
        check("j_jump", 32'(ifid.jump), 32'd1);
        check("j_addr", ifid.jump_address, 32'h4000_0040);
        step();
        check("j_ctrl", 32'(ctrl_ex), 32'd0);
        check("j_pc4", pc4_ex, 32'h4000_0008);

        // jump deferred by a load-use stall
        ifid.Instruccion = 32'h8C22_0004;
        step();
        ifid.Instruccion = 32'h0802_0000;
        #1;
        check("jst_stall", 32'(ifid.stall), 32'd1);
        check("jst_jump", 32'(ifid.jump), 32'd0);
        step();
        check("jst_stall_clear", 32'(ifid.stall), 32'd0);
        check("jst_jump_late", 32'(ifid.jump), 32'd1);
        check("jst_addr", ifid.jump_address, 32'h4008_0000);
        step();

        // sw / beq decode
        ifid.Instruccion = 32'hAC22_0004;
        step();
        check("sw_ctrl", 32'(ctrl_ex), 32'(9'b000101000));
        ifid.Instruccion = 32'h1022_0003;
        step();
        check("beq_ctrl", 32'(ctrl_ex), 32'(9'b000010001));
        check("beq_imm", imm_ex, 32'd3);

        // flush beats stall and jump
        ifid.Instruccion = 32'h8C22_0004;
        step();
        ifid.Instruccion = 32'h0802_0000;
        ifid.flush = 1'b1;
        #1;
        check("fl_stall", 32'(ifid.stall), 32'd0);
        check("fl_jump", 32'(ifid.jump), 32'd0);
        step();
        check("fl_ctrl", 32'(ctrl_ex), 32'd0);
        check("fl_pc4", pc4_ex, 32'd0);
        ifid.flush = 1'b0;

        // addi sign extension and illegal opcode
        ifid.Instruccion = 32'h2001_8000;
        step();
        check("addi_imm", imm_ex, 32'hFFFF_8000);
        check("addi_ctrl", 32'(ctrl_ex), 32'(9'b100001000));
        ifid.Instruccion = 32'hFFFF_1234;
        #1;
        check("ill_jump", 32'(ifid.jump), 32'd0);
        step();
        check("ill_ctrl", 32'(ctrl_ex), 32'd0);

        // reset mid-operation drops the concurrent write and clears the file
        rst = 1'b1;
        wb_en = 1'b1;
        wb_addr = 5'd9;
        wb_data = 32'h0000_ABCD;
        ifid.Instruccion = 32'h2001_8000;
        step();
        check("mrst_ctrl", 32'(ctrl_ex), 32'd0);
        rst = 1'b0;
        wb_en = 1'b0;
        ifid.Instruccion = 32'h0125_0020;
        step();
        check("mrst_r9", rs_data_ex, 32'd0);
        check("mrst_r5", rt_data_ex, 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
